mileage_recorder: RTL and testbench

Accumulates travelled distance for the car model and produces the 27-bit binary mileage `record` consumed by the eight-digit mileage display. While power is on and the vehicle is moving, a prescaler counts clock cycles and adds one mileage unit per `TICKS_PER_UNIT` cycles. The count saturates at the largest value the display can show. A single-cycle update strobe marks every change of `record`.

---
 rtl/mileage_recorder.sv | 98 +++++++++
 tb/tb_mileage_recorder.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mileage_recorder.sv
// Mileage accumulator: a prescaler turns clock cycles into distance units and a
// saturating binary counter feeds the eight-digit mileage display.
module mileage_recorder #(
    parameter int unsigned TICKS_PER_UNIT = 100_000_000,
    parameter int unsigned MAX_RECORD     = 99_999_999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power_now,
    input  logic        moving,
    input  logic        clear,
    output logic [26:0] record,
    output logic        record_update,
    output logic        saturated
);

    localparam int unsigned PW = (TICKS_PER_UNIT > 1) ? $clog2(TICKS_PER_UNIT) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_UNIT - 1);
    localparam logic [26:0]   REC_MAX = 27'(MAX_RECORD);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2,
        ST_SAT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [26:0]   record_q, record_d;
    logic          upd_q, upd_d;
    logic          sat_q, sat_d;

    logic          at_max;
    assign at_max = (record_q == REC_MAX);

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        record_d = record_q;
        upd_d    = 1'b0;
        sat_d    = sat_q;

        // Datapath: power loss discards partial distance, clear beats a wrap.
        if (!power_now) begin
            presc_d = '0;
        end else if (clear) begin
            record_d = '0;
            presc_d  = '0;
            sat_d    = 1'b0;
            upd_d    = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!at_max) begin
                        if (presc_q == PS_LAST) begin
                            presc_d  = '0;
                            record_d = record_q + 27'd1;
                            upd_d    = 1'b1;
                            sat_d    = (record_q + 27'd1 == REC_MAX);
                        end else begin
                            presc_d = presc_q + PW'(1);
                        end
                    end
                end
                ST_IDLE: presc_d = presc_q;
                default: presc_d = '0;
            endcase
        end

        if (!power_now)      state_d = ST_OFF;
        else if (clear)      state_d = ST_IDLE;
        else if (at_max)     state_d = ST_SAT;
        else if (moving)     state_d = ST_RUN;
        else                 state_d = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            presc_q  <= '0;
            record_q <= '0;
            upd_q    <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            record_q <= record_d;
            upd_q    <= upd_d;
            sat_q    <= sat_d;
        end
    end

    assign record        = record_q;
    assign record_update = upd_q;
    assign saturated     = sat_q;

endmodule

// File: tb/tb_mileage_recorder.sv
// Directed bench for mileage_recorder with TICKS_PER_UNIT=4 and MAX_RECORD=10.
module tb_mileage_recorder;

    logic        clk;
    logic        rst_n;
    logic        power_now;
    logic        moving;
    logic        clear;
    logic [26:0] record;
    logic        record_update;
    logic        saturated;

    int checks  = 0;
    int errors  = 0;
    int strobes = 0;

    mileage_recorder #(
        .TICKS_PER_UNIT(4),
        .MAX_RECORD    (10)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .power_now    (power_now),
        .moving       (moving),
        .clear        (clear),
        .record       (record),
        .record_update(record_update),
        .saturated    (saturated)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
        if (record_update === 1'b1) strobes++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst_n = 1'b0; power_now = 1'b0; moving = 1'b0; clear = 1'b0;
        #12;
        chk("rst_record", 32'(record), 0);
        chk("rst_upd", 32'(record_update), 0);
        chk("rst_sat", 32'(saturated), 0);
        rst_n = 1'b1;
        tick();

        // Basic counting: E0 enters RUN, wraps on every 4th edge after it.
        power_now = 1'b1; moving = 1'b1;
        tick();
        strobes = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("cnt_record", 32'(record), 32'(i / 4));
            chk("cnt_upd", 32'(record_update), (i % 4 == 0) ? 1 : 0);
        end
        chk("cnt_strobes", 32'(strobes), 5);
        chk("cnt_sat", 32'(saturated), 0);

        // Pause with prescaler landing at 2, resume needs 2 counting edges.
        tick();
        moving = 1'b0;
        tick();
        strobes = 0;
        ticks(10);
        chk("pause_record", 32'(record), 5);
        chk("pause_strobes", 32'(strobes), 0);
        moving = 1'b1;
        ticks(2);
        chk("resume_hold", 32'(record), 5);
        tick();
        chk("resume_record", 32'(record), 6);
        chk("resume_upd", 32'(record_update), 1);

        // Power loss at record=7, prescaler=3: nothing is lost but the partial unit.
        ticks(7);
        chk("pre_off_record", 32'(record), 7);
        power_now = 1'b0;
        tick();
        chk("off_upd", 32'(record_update), 0);
        ticks(4);
        chk("off_record", 32'(record), 7);
        power_now = 1'b1;
        tick();
        ticks(3);
        chk("on_hold", 32'(record), 7);
        tick();
        chk("on_record", 32'(record), 8);
        chk("on_upd", 32'(record_update), 1);

        // Saturation from zero: exactly 10 increments in 60 cycles.
        clear = 1'b1;
        tick();
        chk("clr_record", 32'(record), 0);
        chk("clr_upd", 32'(record_update), 1);
        clear = 1'b0;
        strobes = 0;
        ticks(60);
        chk("sat_record", 32'(record), 10);
        chk("sat_flag", 32'(saturated), 1);
        chk("sat_strobes", 32'(strobes), 10);
        clear = 1'b1;
        strobes = 0;
        tick();
        chk("sat_clr_record", 32'(record), 0);
        chk("sat_clr_flag", 32'(saturated), 0);
        clear = 1'b0;
        tick();
        chk("sat_clr_strobes", 32'(strobes), 1);
        ticks(4);
        chk("sat_resume", 32'(record), 1);

        // Clear landing on a wrap edge with record=3.
        ticks(11);
        chk("coll_pre", 32'(record), 3);
        clear = 1'b1;
        strobes = 0;
        tick();
        chk("coll_record", 32'(record), 0);
        clear = 1'b0;
        tick();
        chk("coll_strobes", 32'(strobes), 1);
        chk("coll_hold", 32'(record), 0);

        // Clear while power is off is ignored.
        ticks(4);
        chk("poff_pre", 32'(record), 1);
        power_now = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        chk("poff_clr_record", 32'(record), 1);
        chk("poff_clr_upd", 32'(record_update), 0);
        clear = 1'b0;

        // Asynchronous reset while a strobe is visible.
        power_now = 1'b1;
        tick();
        ticks(16);
        chk("ar_pre_record", 32'(record), 5);
        chk("ar_pre_upd", 32'(record_update), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_record", 32'(record), 0);
        chk("ar_upd", 32'(record_update), 0);
        chk("ar_sat", 32'(saturated), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
